// File: rtl/adder_with_flow_control_pkg.sv
// Shared defaults and sizing helpers for the flow-controlled streaming adder.
package adder_with_flow_control_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/flow_control_fifo.sv
// Small synchronous FIFO with occupancy counter; no write-to-read bypass.
module flow_control_fifo
    import adder_with_flow_control_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(depth);
    localparam int CW = fifo_cnt_w(depth);

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(depth));

endmodule

// File: rtl/adder_with_flow_control.sv
// Joins two valid/ready operand streams through per-side FIFOs into one
// registered valid/ready stream of carry-preserving sums.
module adder_with_flow_control
    import adder_with_flow_control_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_vld,
    output logic             a_rdy,
    input  logic [width-1:0] a_data,
    input  logic             b_vld,
    output logic             b_rdy,
    input  logic [width-1:0] b_data,
    output logic             sum_vld,
    input  logic             sum_rdy,
    output logic [width:0]   sum_data
);

    function automatic logic [width:0] add_ext(input logic [width-1:0] x,
                                               input logic [width-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    logic             w_a_push, w_b_push;
    logic             w_a_empty, w_b_empty;
    logic             w_a_full, w_b_full;
    logic [width-1:0] w_a_rd_p0, w_b_rd_p0;
    logic             w_load;
    logic             r_sum_vld_p1;
    logic [width:0]   r_sum_data_p1;

    // Stage p0: operand queues
    assign w_a_push = a_vld & ~w_a_full;
    assign w_b_push = b_vld & ~w_b_full;
    assign w_load   = ~w_a_empty & ~w_b_empty & (~r_sum_vld_p1 | sum_rdy);

    flow_control_fifo #(.width(width), .depth(depth)) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .push    (w_a_push),
        .pop     (w_load),
        .wr_data (a_data),
        .rd_data (w_a_rd_p0),
        .empty   (w_a_empty),
        .full    (w_a_full)
    );

    flow_control_fifo #(.width(width), .depth(depth)) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .push    (w_b_push),
        .pop     (w_load),
        .wr_data (b_data),
        .rd_data (w_b_rd_p0),
        .empty   (w_b_empty),
        .full    (w_b_full)
    );

    // Stage p1: output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_vld_p1  <= 1'b0;
            r_sum_data_p1 <= '0;
        end else if (w_load) begin
            r_sum_vld_p1  <= 1'b1;
            r_sum_data_p1 <= add_ext(w_a_rd_p0, w_b_rd_p0);
        end else if (sum_rdy) begin
            r_sum_vld_p1  <= 1'b0;
        end
    end

    assign a_rdy    = ~w_a_full;
    assign b_rdy    = ~w_b_full;
    assign sum_vld  = r_sum_vld_p1;
    assign sum_data = r_sum_data_p1;

endmodule

// File: tb/tb_adder_with_flow_control.sv
// Directed and randomized-handshake bench for adder_with_flow_control (width 4, depth 4).
module tb_adder_with_flow_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_vld = 1'b0, b_vld = 1'b0, sum_rdy = 1'b0;
    logic [3:0] a_data = '0, b_data = '0;
    logic       a_rdy, b_rdy, sum_vld;
    logic [4:0] sum_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_a = 0, n_b = 0, n_sum = 0;
    logic [4:0] last_sum = '0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    adder_with_flow_control #(.width(4), .depth(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_vld    (a_vld),
        .a_rdy    (a_rdy),
        .a_data   (a_data),
        .b_vld    (b_vld),
        .b_rdy    (b_rdy),
        .b_data   (b_data),
        .sum_vld  (sum_vld),
        .sum_rdy  (sum_rdy),
        .sum_data (sum_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are stable at the falling edge, so handshakes seen here happen at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (sum_vld && sum_rdy) begin
                if (qa.size() == 0 || qb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [4:0] e;
                    e = {1'b0, qa.pop_front()} + {1'b0, qb.pop_front()};
                    check("sum_order", 32'(sum_data), 32'(e));
                end
                last_sum = sum_data;
                n_sum++;
            end
            if (a_vld && a_rdy) begin qa.push_back(a_data); n_a++; end
            if (b_vld && b_rdy) begin qb.push_back(b_data); n_b++; end
        end
    end

    task automatic drive(input logic av, input logic [3:0] ad,
                         input logic bv, input logic [3:0] bd, input logic sr);
        @(posedge clk); #1;
        a_vld = av; a_data = ad; b_vld = bv; b_data = bd; sum_rdy = sr;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    initial begin
        int s0, a0, b0, cyc;
        logic [4:0] hold;
        logic stable;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum_vld", 32'(sum_vld), 32'd0);
        check("rst_sum_data", 32'(sum_data), 32'd0);
        check("rst_a_rdy", 32'(a_rdy), 32'd1);
        check("rst_b_rdy", 32'(b_rdy), 32'd1);
        @(negedge clk); rst = 1'b0;

        // Back-to-back streaming
        for (int i = 0; i < 20; i++) begin
            if (i == 7) drive(1'b1, 4'hF, 1'b1, 4'hF, 1'b1);
            else        drive(1'b1, 4'(i), 1'b1, 4'(i * 3), 1'b1);
            if (i == 5) begin sample(); s0 = n_sum; end
            if (i == 15) begin sample(); check("b2b_throughput", 32'(n_sum - s0), 32'd10); end
        end
        repeat (3) drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sample();
        check("b2b_drained", 32'(qa.size() + qb.size()), 32'd0);

        // Single transfer latency and carry: F + F
        drive(1'b1, 4'hF, 1'b1, 4'hF, 1'b1);
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sample();
        check("lat_not_yet", 32'(sum_vld), 32'd0);
        sample();
        check("lat_vld", 32'(sum_vld), 32'd1);
        check("carry_FF", 32'(sum_data), 32'h1E);

        // A only, then B
        a0 = n_a;
        for (int i = 0; i < 6; i++) drive(1'b1, 4'(i + 1), 1'b0, 4'h0, 1'b1);
        sample();
        check("aonly_a_rdy", 32'(a_rdy), 32'd0);
        check("aonly_sum_vld", 32'(sum_vld), 32'd0);
        check("aonly_accepts", 32'(n_a - a0), 32'd4);
        s0 = n_sum;
        for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 1'b1, 4'(8 + i), 1'b1);
        repeat (4) drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sample();
        check("aonly_a_rdy_back", 32'(a_rdy), 32'd1);
        check("aonly_sums", 32'(n_sum - s0), 32'd4);
        check("aonly_last", 32'(last_sum), 32'h0F);

        // B only, then A
        b0 = n_b;
        for (int i = 0; i < 6; i++) drive(1'b0, 4'h0, 1'b1, 4'(2 * (i + 1)), 1'b1);
        sample();
        check("bonly_b_rdy", 32'(b_rdy), 32'd0);
        check("bonly_sum_vld", 32'(sum_vld), 32'd0);
        check("bonly_accepts", 32'(n_b - b0), 32'd4);
        s0 = n_sum;
        drive(1'b1, 4'hD, 1'b0, 4'h0, 1'b1);
        drive(1'b1, 4'hE, 1'b0, 4'h0, 1'b1);
        drive(1'b1, 4'hF, 1'b0, 4'h0, 1'b1);
        drive(1'b1, 4'h1, 1'b0, 4'h0, 1'b1);
        repeat (4) drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sample();
        check("bonly_b_rdy_back", 32'(b_rdy), 32'd1);
        check("bonly_sums", 32'(n_sum - s0), 32'd4);
        check("bonly_last", 32'(last_sum), 32'h09);

        // Backpressure
        a0 = n_a; b0 = n_b; stable = 1'b1; hold = '0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'(i + 3), 1'b1, 4'(i + 5), 1'b0);
            sample();
            if (i == 2) hold = sum_data;
            if (i > 2 && (sum_data !== hold || sum_vld !== 1'b1)) stable = 1'b0;
        end
        check("bp_first_sum", 32'(hold), 32'h08);
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_a_rdy", 32'(a_rdy), 32'd0);
        check("bp_b_rdy", 32'(b_rdy), 32'd0);
        check("bp_a_accepts", 32'(n_a - a0), 32'd5);
        check("bp_b_accepts", 32'(n_b - b0), 32'd5);
        s0 = n_sum;
        repeat (8) drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sample();
        check("bp_drain_sums", 32'(n_sum - s0), 32'd5);
        check("bp_drain_last", 32'(last_sum), 32'h10);

        // Random handshakes, 100 transfers per side
        a0 = n_a; b0 = n_b; s0 = n_sum; cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (n_a - a0 >= 100 && n_b - b0 >= 100) break;
            a_vld   = (n_a - a0 < 100) && ($urandom_range(1, 0) == 1);
            b_vld   = (n_b - b0 < 100) && ($urandom_range(1, 0) == 1);
            a_data  = 4'($urandom);
            b_data  = 4'($urandom);
            sum_rdy = ($urandom_range(3, 0) != 0);
        end
        a_vld = 1'b0; b_vld = 1'b0; sum_rdy = 1'b1;
        check("rand_timeout", 32'(cyc < 3000), 32'd1);
        repeat (11) @(posedge clk);
        sample();
        check("rand_a_count", 32'(n_a - a0), 32'd100);
        check("rand_b_count", 32'(n_b - b0), 32'd100);
        check("rand_sum_count", 32'(n_sum - s0), 32'd100);
        check("rand_pending", 32'(qa.size() + qb.size() + int'(sum_vld)), 32'd0);

        // Asynchronous reset mid-stream
        repeat (3) drive(1'b1, 4'h6, 1'b1, 4'h9, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0;
        #1;
        check("arst_sum_vld", 32'(sum_vld), 32'd0);
        check("arst_sum_data", 32'(sum_data), 32'd0);
        check("arst_a_rdy", 32'(a_rdy), 32'd1);
        check("arst_b_rdy", 32'(b_rdy), 32'd1);
        qa.delete(); qb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #2; rst = 1'b0;
        repeat (3) drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sample();
        check("arst_no_stale", 32'(sum_vld), 32'd0);
        drive(1'b1, 4'h3, 1'b1, 4'h4, 1'b1);
        drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sample();
        sample();
        check("arst_after_vld", 32'(sum_vld), 32'd1);
        check("arst_after_data", 32'(sum_data), 32'h07);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
